// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: round-robin share of one DDR2 burst port among four slaves' write/read streams
module ddr_burst_arbiter #(
    parameter int          BURST_LEN = 256,
    parameter logic [20:0] MAX_ADDR  = 21'd245_760
) (
    input  logic        phy_clk,
    input  logic        rst_n,
    input  logic [3:0]  wr_req,
    input  logic [3:0]  rd_req,
    input  logic [3:0]  wr_addr_clr,
    input  logic [3:0]  rd_addr_clr,
    input  logic        ready,
    input  logic        mem_wen_valid,
    input  logic        mem_ren_valid,
    input  logic        wr_burst_finish,
    input  logic        rd_burst_finish,
    output logic [22:0] wr_addr,
    output logic [9:0]  w_len,
    output logic        mem_wen,
    output logic [22:0] rd_addr,
    output logic [9:0]  r_len,
    output logic        mem_ren,
    output logic [1:0]  wr_gnt,
    output logic        wr_gnt_vld,
    output logic [1:0]  rd_gnt,
    output logic        rd_gnt_vld
);
    localparam logic [20:0] BL  = 21'(BURST_LEN);
    localparam logic [9:0]  LEN = 10'(BURST_LEN);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
    state_t      state;
    logic [20:0] wr_off [4];
    logic [20:0] rd_off [4];
    logic [1:0]  wr_ptr, rd_ptr, win;
    logic        pref_rd, wr_pend, rd_pend, go, take_rd;
    logic [2:0]  wr_pick, rd_pick;
    logic [20:0] win_off, wr_nxt, rd_nxt;
    // {found, index}: first requester after ptr, ptr itself searched last
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 4; k >= 1; k--)
            if (req[ptr + 2'(k)]) r = {1'b1, ptr + 2'(k)};
        return r;
    endfunction
    // arbitration decision and the offset a new grant would use (a same-cycle clear wins)
    always_comb begin
        wr_pick = rr_pick(wr_req, wr_ptr);
        rd_pick = rr_pick(rd_req, rd_ptr);
        go      = ready && (wr_pick[2] || rd_pick[2]);
        take_rd = rd_pick[2] && (!wr_pick[2] || pref_rd);
        win     = take_rd ? rd_pick[1:0] : wr_pick[1:0];
        win_off = take_rd ? (rd_addr_clr[win] ? 21'd0 : rd_off[win])
                          : (wr_addr_clr[win] ? 21'd0 : wr_off[win]);
        wr_nxt  = wr_off[wr_gnt] + BL;
        rd_nxt  = rd_off[rd_gnt] + BL;
    end
    // burst FSM, grant/request outputs and per-slave frame offsets
    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pref_rd    <= 1'b0;
            wr_ptr     <= 2'd3;
            rd_ptr     <= 2'd3;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_gnt     <= '0;
            rd_gnt     <= '0;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
            wr_gnt_vld <= 1'b0;
            rd_gnt_vld <= 1'b0;
            w_len      <= LEN;
            r_len      <= LEN;
            for (int i = 0; i < 4; i++) begin
                wr_off[i] <= '0;
                rd_off[i] <= '0;
            end
        end else begin
            w_len <= LEN;
            r_len <= LEN;
            for (int i = 0; i < 4; i++) begin
                if (wr_addr_clr[i]) begin
                    if (wr_gnt_vld && wr_gnt == 2'(i)) wr_pend <= 1'b1;
                    else wr_off[i] <= '0;
                end
                if (rd_addr_clr[i]) begin
                    if (rd_gnt_vld && rd_gnt == 2'(i)) rd_pend <= 1'b1;
                    else rd_off[i] <= '0;
                end
            end
            case (state)
                IDLE: if (go) begin
                    pref_rd <= ~pref_rd;
                    if (take_rd) begin
                        rd_ptr     <= win;
                        rd_gnt     <= win;
                        rd_addr    <= {win, win_off};
                        mem_ren    <= 1'b1;
                        rd_gnt_vld <= 1'b1;
                        state      <= RD_REQ;
                    end else begin
                        wr_ptr     <= win;
                        wr_gnt     <= win;
                        wr_addr    <= {win, win_off};
                        mem_wen    <= 1'b1;
                        wr_gnt_vld <= 1'b1;
                        state      <= WR_REQ;
                    end
                end
                WR_REQ: if (mem_wen_valid) begin
                    mem_wen <= 1'b0;
                    state   <= WR_WAIT;
                end
                WR_WAIT: if (wr_burst_finish) begin
                    wr_off[wr_gnt] <= (wr_pend || wr_addr_clr[wr_gnt] || wr_nxt == MAX_ADDR) ? 21'd0 : wr_nxt;
                    wr_pend        <= 1'b0;
                    wr_gnt_vld     <= 1'b0;
                    state          <= IDLE;
                end
                RD_REQ: if (mem_ren_valid) begin
                    mem_ren <= 1'b0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: if (rd_burst_finish) begin
                    rd_off[rd_gnt] <= (rd_pend || rd_addr_clr[rd_gnt] || rd_nxt == MAX_ADDR) ? 21'd0 : rd_nxt;
                    rd_pend        <= 1'b0;
                    rd_gnt_vld     <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: scoreboard bench acting as the DDR controller for the burst arbiter
module tb_ddr_burst_arbiter;
    logic        phy_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  wr_req = '0, rd_req = '0, wr_addr_clr = '0, rd_addr_clr = '0;
    logic        ready = 1'b0, mem_wen_valid = 1'b0, mem_ren_valid = 1'b0;
    logic        wr_burst_finish = 1'b0, rd_burst_finish = 1'b0;
    logic [22:0] wr_addr, rd_addr;
    logic [9:0]  w_len, r_len;
    logic        mem_wen, mem_ren, wr_gnt_vld, rd_gnt_vld;
    logic [1:0]  wr_gnt, rd_gnt;
    int          n_chk = 0, n_fail = 0;
    typedef struct packed {
        logic        rd;
        logic [22:0] addr;
    } exp_t;
    exp_t sb[$];

    ddr_burst_arbiter dut (
        .phy_clk(phy_clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .wr_addr_clr(wr_addr_clr), .rd_addr_clr(rd_addr_clr), .ready(ready),
        .mem_wen_valid(mem_wen_valid), .mem_ren_valid(mem_ren_valid),
        .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
        .wr_addr(wr_addr), .w_len(w_len), .mem_wen(mem_wen),
        .rd_addr(rd_addr), .r_len(r_len), .mem_ren(mem_ren),
        .wr_gnt(wr_gnt), .wr_gnt_vld(wr_gnt_vld), .rd_gnt(rd_gnt), .rd_gnt_vld(rd_gnt_vld)
    );

    always #5 phy_clk = ~phy_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_burst(input logic rd, input logic [22:0] a);
        sb.push_back({rd, a});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_req = '0;
        rd_req = '0;
        repeat (2) @(negedge phy_clk);
        rst_n = 1'b1;
    endtask

    // plays the controller for n bursts; requests are dropped with the last finish
    task automatic serve(input int n, input int clr_at = -1, input logic [3:0] clr_mask = '0);
        for (int b = 0; b < n; b++) begin
            int   t = 0;
            exp_t e;
            logic rd;
            while (!(mem_wen || mem_ren) && t < 20) begin
                @(negedge phy_clk);
                t++;
            end
            if (t >= 20) begin
                check("grant_timeout", 0, 1);
                return;
            end
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
                return;
            end
            e  = sb.pop_front();
            rd = mem_ren;
            check("req_latency", t, 1);
            check("dir", rd, e.rd);
            check("addr", rd ? rd_addr : wr_addr, e.addr);
            check("gnt", rd ? rd_gnt : wr_gnt, e.addr[22:21]);
            check("gnt_vld", rd ? rd_gnt_vld : wr_gnt_vld, 1);
            check("len", rd ? r_len : w_len, 256);
            check("one_outstanding", mem_wen & mem_ren, 0);
            @(negedge phy_clk);
            check("req_hold", rd ? mem_ren : mem_wen, 1);
            if (rd) mem_ren_valid = 1'b1;
            else mem_wen_valid = 1'b1;
            @(negedge phy_clk);
            mem_ren_valid = 1'b0;
            mem_wen_valid = 1'b0;
            check("req_drop", rd ? mem_ren : mem_wen, 0);
            check("gnt_vld_wait", rd ? rd_gnt_vld : wr_gnt_vld, 1);
            if (b == clr_at) begin
                if (rd) rd_addr_clr = clr_mask;
                else wr_addr_clr = clr_mask;
            end
            @(negedge phy_clk);
            wr_addr_clr = '0;
            rd_addr_clr = '0;
            check("addr_stable", rd ? rd_addr : wr_addr, e.addr);
            if (rd) rd_burst_finish = 1'b1;
            else wr_burst_finish = 1'b1;
            if (b == n - 1) begin
                wr_req = '0;
                rd_req = '0;
            end
            @(negedge phy_clk);
            wr_burst_finish = 1'b0;
            rd_burst_finish = 1'b0;
            check("gnt_vld_drop", rd ? rd_gnt_vld : wr_gnt_vld, 0);
        end
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge phy_clk);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_wr_gnt_vld", wr_gnt_vld, 0);
        check("rst_rd_gnt_vld", rd_gnt_vld, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_w_len", w_len, 256);
        check("rst_r_len", r_len, 256);
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge phy_clk);
        // basic write: slave 0 twice
        wr_req = 4'b0001;
        expect_burst(1'b0, 23'h000000);
        expect_burst(1'b0, 23'h000100);
        serve(2);
        repeat (2) @(negedge phy_clk);
        check("idle_no_wen", mem_wen, 0);
        // round-robin
        do_reset();
        wr_req = 4'b1111;
        for (int i = 0; i < 4; i++) expect_burst(1'b0, {2'(i), 21'd0});
        expect_burst(1'b0, 23'h000100);
        serve(5);
        // mixed traffic alternates direction
        do_reset();
        wr_req = 4'b0010;
        rd_req = 4'b0100;
        expect_burst(1'b0, 23'h200000);
        expect_burst(1'b1, 23'h400000);
        expect_burst(1'b0, 23'h200100);
        serve(3);
        // frame wrap on slave 3
        do_reset();
        wr_req = 4'b1000;
        for (int k = 0; k <= 960; k++) expect_burst(1'b0, {2'b11, (k == 960) ? 21'd0 : 21'(k * 256)});
        serve(961);
        // clear while owner (slave 0 at 512) plus immediate clear of slave 1
        do_reset();
        wr_req = 4'b0011;
        expect_burst(1'b0, 23'h000000);
        expect_burst(1'b0, 23'h200000);
        expect_burst(1'b0, 23'h000100);
        expect_burst(1'b0, 23'h200100);
        expect_burst(1'b0, 23'h000200);
        expect_burst(1'b0, 23'h200000);
        expect_burst(1'b0, 23'h000000);
        serve(7, 4, 4'b0011);
        // reset mid-burst in RD_WAIT
        do_reset();
        rd_req = 4'b0001;
        expect_burst(1'b1, 23'h000000);
        serve(1);
        rd_req = 4'b0001;
        @(negedge phy_clk);
        check("rd2_mem_ren", mem_ren, 1);
        check("rd2_addr", rd_addr, 23'h000100);
        mem_ren_valid = 1'b1;
        @(negedge phy_clk);
        mem_ren_valid = 1'b0;
        rd_req = '0;
        check("rd2_in_wait", rd_gnt_vld, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_ren", mem_ren, 0);
        check("async_rst_rd_gnt_vld", rd_gnt_vld, 0);
        check("async_rst_rd_addr", rd_addr, 0);
        @(negedge phy_clk);
        rst_n = 1'b1;
        rd_burst_finish = 1'b1;
        mem_wen_valid = 1'b1;
        @(negedge phy_clk);
        rd_burst_finish = 1'b0;
        mem_wen_valid = 1'b0;
        check("stray_rd_gnt_vld", rd_gnt_vld, 0);
        check("stray_mem_ren", mem_ren, 0);
        check("stray_mem_wen", mem_wen, 0);
        rd_req = 4'b0001;
        expect_burst(1'b1, 23'h000000);
        serve(1);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
